// File: rtl/wombat_axis_pkg.sv
// Shared width constants, FSM state type and tkeep helpers for the wombat
// AXI4-Stream blocks.
package wombat_axis_pkg;

  localparam int DATA_WIDTH  = 256;
  localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
  localparam int TUSER_WIDTH = 128;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } pkt_state_e;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

  // True when keep is non-empty and its set bits run contiguously up from bit 0.
  function automatic logic keep_contig(input logic [31:0] k);
    return (k != '0) && ((k & (k + 32'd1)) == '0);
  endfunction

endpackage

// File: rtl/axis_pkt_sink_if.sv
// AXI4-Stream beat bundle between a stream source (master) and the packet sink (slave).
interface axis_pkt_sink_if
  import wombat_axis_pkg::*;
#(
  parameter int DATA_W  = DATA_WIDTH,
  parameter int TUSER_W = TUSER_WIDTH
) ();

  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic [TUSER_W-1:0]  tuser;
  logic                tvalid;
  logic                tlast;
  logic                tready;

  modport master (
    output tdata, tkeep, tuser, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/axis_cap_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port.
// A read of the word being written in the same cycle returns the old contents.
module axis_cap_ram #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 289,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axis_pkt_sink.sv
// AXI4-Stream packet sink: patterned backpressure, protocol checking,
// packet/beat/byte statistics and capture of accepted beats.
//
// state     | meaning
// ST_IDLE   | between packets; next accepted beat is a packet's first beat
// ST_IN_PKT | first beat accepted, waiting for the tlast beat
module axis_pkt_sink
  import wombat_axis_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = DATA_WIDTH,
  parameter int C_S_AXIS_TUSER_WIDTH = TUSER_WIDTH,
  parameter int CAP_DEPTH            = 512,
  parameter int MAX_PKT_BEATS        = 64,
  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8,
  localparam int ADDR_W = $clog2(CAP_DEPTH),
  localparam int CAP_W  = C_S_AXIS_DATA_WIDTH + KEEP_W + 1
) (
  input  logic                            axis_aclk,
  input  logic                            axis_reset,
  axis_pkt_sink_if.slave                  s_axis,
  input  logic                            enable,
  input  logic [15:0]                     ready_pattern,
  input  logic                            clear,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic [CAP_W-1:0]                rd_data,
  output logic [ADDR_W:0]                 cap_count,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     beat_count,
  output logic [47:0]                     byte_count,
  output logic                            pkt_done,
  output logic [15:0]                     pkt_bytes,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0] first_tuser,
  output logic                            err_keep,
  output logic                            err_hold,
  output logic                            err_len,
  output logic                            err_overflow
);

  localparam int IDX_W = $clog2(MAX_PKT_BEATS + 2) + 1;
  localparam logic [IDX_W-1:0] LEN_LIMIT = IDX_W'(MAX_PKT_BEATS + 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [ADDR_W:0]  CAP_ONE   = (ADDR_W + 1)'(1);

  pkt_state_e                      state_q;
  pkt_state_e                      state_d;
  logic [3:0]                      pptr;
  logic                            tready_q;
  logic                            take;
  logic                            take_last;
  logic [5:0]                      beat_bytes;
  logic [16:0]                     bytes_sum;
  logic [15:0]                     bytes_sat;
  logic [15:0]                     run_bytes;
  logic [IDX_W-1:0]                beat_idx;
  logic [IDX_W-1:0]                idx_next;
  logic                            keep_bad;
  logic                            cap_full;
  logic                            wr_en;
  logic [CAP_W-1:0]                cap_wdata;
  logic [CAP_W-1:0]                hold_beat;
  logic [C_S_AXIS_TUSER_WIDTH-1:0] hold_user;
  logic                            stall_q;
  logic                            hold_viol;

  assign s_axis.tready = tready_q;

  // clear takes priority over a coincident handshake: the beat is dropped.
  assign take      = s_axis.tvalid & tready_q & ~clear;
  assign take_last = take & s_axis.tlast;

  assign beat_bytes = popcount32(32'(s_axis.tkeep));
  assign bytes_sum  = {1'b0, run_bytes} + 17'(beat_bytes);
  assign bytes_sat  = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
  assign idx_next   = (beat_idx == LEN_LIMIT) ? beat_idx : beat_idx + IDX_ONE;

  assign keep_bad = s_axis.tlast ? ~keep_contig(32'(s_axis.tkeep)) : ~(&s_axis.tkeep);

  // cap_count never exceeds CAP_DEPTH, so its MSB alone marks a full RAM.
  assign cap_full  = cap_count[ADDR_W];
  assign wr_en     = take & ~cap_full;
  assign cap_wdata = {s_axis.tdata, s_axis.tkeep, s_axis.tlast};

  assign hold_viol = stall_q & (~s_axis.tvalid
                                | (cap_wdata != hold_beat)
                                | (s_axis.tuser != hold_user));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (take && !s_axis.tlast) state_d = ST_IN_PKT;
      ST_IN_PKT: if (take_last)             state_d = ST_IDLE;
      default:                              state_d = ST_IDLE;
    endcase
  end

  // clear also discards any partial packet so the accumulators stay coherent.
  always_ff @(posedge axis_aclk) begin
    if (axis_reset || clear) begin
      state_q      <= ST_IDLE;
      pptr         <= '0;
      tready_q     <= 1'b0;
      cap_count    <= '0;
      pkt_count    <= '0;
      beat_count   <= '0;
      byte_count   <= '0;
      pkt_done     <= 1'b0;
      pkt_bytes    <= '0;
      first_tuser  <= '0;
      run_bytes    <= '0;
      beat_idx     <= '0;
      err_keep     <= 1'b0;
      err_hold     <= 1'b0;
      err_len      <= 1'b0;
      err_overflow <= 1'b0;
      stall_q      <= 1'b0;
      hold_beat    <= '0;
      hold_user    <= '0;
    end else begin
      state_q   <= state_d;
      pptr      <= pptr + 4'd1;
      tready_q  <= enable & ready_pattern[pptr];
      pkt_done  <= take_last;
      stall_q   <= s_axis.tvalid & ~tready_q;
      hold_beat <= cap_wdata;
      hold_user <= s_axis.tuser;

      if (hold_viol) begin
        err_hold <= 1'b1;
      end

      if (take) begin
        beat_count <= beat_count + 32'd1;
        byte_count <= byte_count + 48'(beat_bytes);
        if (state_q == ST_IDLE) begin
          first_tuser <= s_axis.tuser;
        end
        if (keep_bad) begin
          err_keep <= 1'b1;
        end
        if (idx_next == LEN_LIMIT) begin
          err_len <= 1'b1;
        end
        if (cap_full) begin
          err_overflow <= 1'b1;
        end else begin
          cap_count <= cap_count + CAP_ONE;
        end
        if (s_axis.tlast) begin
          pkt_count <= pkt_count + 32'd1;
          pkt_bytes <= bytes_sat;
          run_bytes <= '0;
          beat_idx  <= '0;
        end else begin
          run_bytes <= bytes_sat;
          beat_idx  <= idx_next;
        end
      end
    end
  end

  axis_cap_ram #(
    .DEPTH (CAP_DEPTH),
    .WIDTH (CAP_W)
  ) u_cap_ram (
    .clk     (axis_aclk),
    .wr_en   (wr_en),
    .wr_addr (cap_count[ADDR_W-1:0]),
    .wr_data (cap_wdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_axis_pkt_sink.sv
// Directed bench for axis_pkt_sink: statistics, backpressure, keep/hold/length
// checks, capture overflow and readback, clear and mid-packet reset.
module tb_axis_pkt_sink;

  localparam int DW    = 256;
  localparam int KW    = 32;
  localparam int UW    = 128;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int MAXB  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          enable;
  logic [15:0]   pattern;
  logic          clear;
  logic [AW-1:0] rd_addr;
  logic [DW+KW:0] rd_data;
  logic [AW:0]   cap_count;
  logic [31:0]   pkt_count;
  logic [31:0]   beat_count;
  logic [47:0]   byte_count;
  logic          pkt_done;
  logic [15:0]   pkt_bytes;
  logic [UW-1:0] first_tuser;
  logic          err_keep, err_hold, err_len, err_overflow;

  int checks   = 0;
  int failures = 0;

  axis_pkt_sink_if #(.DATA_W(DW), .TUSER_W(UW)) bus ();

  axis_pkt_sink #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .CAP_DEPTH            (DEPTH),
    .MAX_PKT_BEATS        (MAXB)
  ) dut (
    .axis_aclk     (clk),
    .axis_reset    (rst),
    .s_axis        (bus),
    .enable        (enable),
    .ready_pattern (pattern),
    .clear         (clear),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .cap_count     (cap_count),
    .pkt_count     (pkt_count),
    .beat_count    (beat_count),
    .byte_count    (byte_count),
    .pkt_done      (pkt_done),
    .pkt_bytes     (pkt_bytes),
    .first_tuser   (first_tuser),
    .err_keep      (err_keep),
    .err_hold      (err_hold),
    .err_len       (err_len),
    .err_overflow  (err_overflow)
  );

  function automatic logic [DW-1:0] mk(input int i);
    return {8{32'hC0DE0000 | 32'(i)}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic [UW-1:0] u, input logic l);
    logic done;
    int   guard;
    done  = 1'b0;
    guard = 0;
    bus.tdata  = d;
    bus.tkeep  = k;
    bus.tuser  = u;
    bus.tlast  = l;
    bus.tvalid = 1'b1;
    while (!done) begin
      done = bus.tready;
      tick();
      guard++;
      if (!done && guard > 64) begin
        checks++; failures++;
        $display("FAIL send_timeout tready low for %0d cycles, required a handshake", guard);
        done = 1'b1;
      end
    end
    bus.tvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; pattern = 16'hFFFF; clear = 1'b0; rd_addr = '0;
    bus.tvalid = 1'b0; bus.tdata = '0; bus.tkeep = '0; bus.tuser = '0; bus.tlast = 1'b0;
    repeat (3) tick();
    checks++; if (bus.tready !== 1'b0) begin failures++; $display("FAIL rst_tready got=%b exp=0", bus.tready); end
    checks++; if (pkt_count !== 32'd0) begin failures++; $display("FAIL rst_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (beat_count !== 32'd0) begin failures++; $display("FAIL rst_beat_count got=%0d exp=0", beat_count); end
    checks++; if (cap_count !== 4'd0) begin failures++; $display("FAIL rst_cap_count got=%0d exp=0", cap_count); end
    checks++; if ({pkt_done, err_keep, err_hold, err_len, err_overflow} !== 5'b0) begin
      failures++; $display("FAIL rst_flags got=%b exp=00000", {pkt_done, err_keep, err_hold, err_len, err_overflow});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic_packet();
    pattern = 16'hFFFF;
    do_clear();
    send_beat(mk(1), 32'hFFFFFFFF, 128'h1111, 1'b0);
    send_beat(mk(2), 32'hFFFFFFFF, 128'h2222, 1'b0);
    send_beat(mk(3), 32'h0000000F, 128'h3333, 1'b1);
    checks++; if (pkt_done !== 1'b1) begin failures++; $display("FAIL t1_pkt_done got=%b exp=1", pkt_done); end
    checks++; if (pkt_bytes !== 16'd68) begin failures++; $display("FAIL t1_pkt_bytes got=%0d exp=68", pkt_bytes); end
    checks++; if (pkt_count !== 32'd1) begin failures++; $display("FAIL t1_pkt_count got=%0d exp=1", pkt_count); end
    checks++; if (beat_count !== 32'd3) begin failures++; $display("FAIL t1_beat_count got=%0d exp=3", beat_count); end
    checks++; if (byte_count !== 48'd68) begin failures++; $display("FAIL t1_byte_count got=%0d exp=68", byte_count); end
    checks++; if (first_tuser !== 128'h1111) begin failures++; $display("FAIL t1_first_tuser got=%h exp=1111", first_tuser); end
    checks++; if ({err_keep, err_hold, err_len, err_overflow} !== 4'b0) begin
      failures++; $display("FAIL t1_errors got=%b exp=0000", {err_keep, err_hold, err_len, err_overflow});
    end
    tick();
    checks++; if (pkt_done !== 1'b0) begin failures++; $display("FAIL t1_pkt_done_pulse got=%b exp=0", pkt_done); end
    rd_addr = 3'd2;
    tick();
    checks++; if (rd_data !== {mk(3), 32'h0000000F, 1'b1}) begin
      failures++; $display("FAIL t1_rd_addr2 got=%h exp=%h", rd_data, {mk(3), 32'h0000000F, 1'b1});
    end
  endtask

  task automatic test_backpressure();
    pattern = 16'hAAAA;
    do_clear();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.tready !== pattern[k]) begin
        failures++; $display("FAIL t2_tready_cycle%0d got=%b exp=%b", k, bus.tready, pattern[k]);
      end
    end
    for (int k = 0; k < 4; k++) send_beat(mk(10 + k), 32'hFFFFFFFF, 128'hA0, k == 3);
    checks++; if (err_hold !== 1'b0) begin failures++; $display("FAIL t2_hold_clean got=%b exp=0", err_hold); end
    checks++; if (pkt_bytes !== 16'd128) begin failures++; $display("FAIL t2_pkt_bytes got=%0d exp=128", pkt_bytes); end
    checks++; if (cap_count !== 4'd4) begin failures++; $display("FAIL t2_cap_count got=%0d exp=4", cap_count); end
    for (int k = 0; k < 4; k++) begin
      rd_addr = AW'(k);
      tick();
      checks++; if (rd_data !== {mk(10 + k), 32'hFFFFFFFF, k == 3}) begin
        failures++; $display("FAIL t2_capture%0d got=%h exp=%h", k, rd_data, {mk(10 + k), 32'hFFFFFFFF, k == 3});
      end
    end
    // The first two edges after clear always see tready low.
    do_clear();
    bus.tdata = mk(20); bus.tkeep = 32'hFFFFFFFF; bus.tuser = 128'hB0; bus.tlast = 1'b1;
    bus.tvalid = 1'b1;
    tick();
    checks++; if (err_hold !== 1'b0) begin failures++; $display("FAIL t2_hold_stable got=%b exp=0", err_hold); end
    bus.tdata = mk(21);
    tick();
    bus.tvalid = 1'b0;
    checks++; if (err_hold !== 1'b1) begin failures++; $display("FAIL t2_hold_changed got=%b exp=1", err_hold); end
  endtask

  task automatic test_keep();
    pattern = 16'hFFFF;
    do_clear();
    send_beat(mk(30), 32'h7FFFFFFF, 128'hC0, 1'b0);
    send_beat(mk(31), 32'hFFFFFFFF, 128'hC1, 1'b1);
    checks++; if (err_keep !== 1'b1) begin failures++; $display("FAIL t3_keep_nonlast got=%b exp=1", err_keep); end
    checks++; if (pkt_bytes !== 16'd63) begin failures++; $display("FAIL t3_bytes_63 got=%0d exp=63", pkt_bytes); end
    do_clear();
    send_beat(mk(32), 32'h00000005, 128'hC2, 1'b1);
    checks++; if (err_keep !== 1'b1) begin failures++; $display("FAIL t3_keep_gap got=%b exp=1", err_keep); end
    checks++; if (pkt_bytes !== 16'd2) begin failures++; $display("FAIL t3_bytes_2 got=%0d exp=2", pkt_bytes); end
    do_clear();
    send_beat(mk(33), 32'h00000001, 128'hC3, 1'b1);
    checks++; if (err_keep !== 1'b0) begin failures++; $display("FAIL t3_keep_one got=%b exp=0", err_keep); end
    checks++; if (pkt_bytes !== 16'd1) begin failures++; $display("FAIL t3_bytes_1 got=%0d exp=1", pkt_bytes); end
    checks++; if (first_tuser !== 128'hC3) begin failures++; $display("FAIL t3_first_tuser got=%h exp=c3", first_tuser); end
    send_beat(mk(34), 32'h0000FFFF, 128'hC4, 1'b1);
    checks++; if (err_keep !== 1'b0) begin failures++; $display("FAIL t3_keep_half got=%b exp=0", err_keep); end
    checks++; if (pkt_bytes !== 16'd16) begin failures++; $display("FAIL t3_bytes_16 got=%0d exp=16", pkt_bytes); end
    send_beat(mk(35), 32'h00000000, 128'hC5, 1'b1);
    checks++; if (err_keep !== 1'b1) begin failures++; $display("FAIL t3_keep_zero got=%b exp=1", err_keep); end
    checks++; if (pkt_count !== 32'd3) begin failures++; $display("FAIL t3_pkt_count got=%0d exp=3", pkt_count); end
  endtask

  task automatic test_overflow();
    pattern = 16'hFFFF;
    do_clear();
    for (int i = 0; i < 10; i++) begin
      send_beat(mk(40 + i), 32'hFFFFFFFF, 128'hD0, i == 9);
      if (i == 7) begin
        checks++; if (err_overflow !== 1'b0) begin failures++; $display("FAIL t4_ovf_at_full got=%b exp=0", err_overflow); end
      end
      if (i == 8) begin
        checks++; if (err_overflow !== 1'b1) begin failures++; $display("FAIL t4_ovf_first_drop got=%b exp=1", err_overflow); end
      end
    end
    checks++; if (cap_count !== 4'd8) begin failures++; $display("FAIL t4_cap_count got=%0d exp=8", cap_count); end
    checks++; if (beat_count !== 32'd10) begin failures++; $display("FAIL t4_beat_count got=%0d exp=10", beat_count); end
    checks++; if (byte_count !== 48'd320) begin failures++; $display("FAIL t4_byte_count got=%0d exp=320", byte_count); end
    rd_addr = 3'd7;
    tick();
    checks++; if (rd_data !== {mk(47), 32'hFFFFFFFF, 1'b0}) begin
      failures++; $display("FAIL t4_rd_addr7 got=%h exp=%h", rd_data, {mk(47), 32'hFFFFFFFF, 1'b0});
    end
  endtask

  task automatic test_len_and_clear();
    pattern = 16'hFFFF;
    do_clear();
    for (int i = 0; i <= MAXB; i++) begin
      send_beat(mk(i), 32'hFFFFFFFF, 128'hE0, i == MAXB);
      if (i == MAXB - 1) begin
        checks++; if (err_len !== 1'b0) begin failures++; $display("FAIL t5_len_at_max got=%b exp=0", err_len); end
      end
    end
    checks++; if (err_len !== 1'b1) begin failures++; $display("FAIL t5_len_over got=%b exp=1", err_len); end
    checks++; if (pkt_bytes !== 16'd2080) begin failures++; $display("FAIL t5_pkt_bytes got=%0d exp=2080", pkt_bytes); end
    do_clear();
    checks++; if ({pkt_count, beat_count} !== 64'd0) begin
      failures++; $display("FAIL t5_clear_counts got=%0d/%0d exp=0/0", pkt_count, beat_count);
    end
    checks++; if ({byte_count, pkt_bytes, cap_count} !== 68'd0) begin
      failures++; $display("FAIL t5_clear_bytes got=%0d/%0d/%0d exp=0/0/0", byte_count, pkt_bytes, cap_count);
    end
    checks++; if ({err_keep, err_hold, err_len, err_overflow, pkt_done, bus.tready} !== 6'b0) begin
      failures++; $display("FAIL t5_clear_flags got=%b exp=000000", {err_keep, err_hold, err_len, err_overflow, pkt_done, bus.tready});
    end
    checks++; if (first_tuser !== 128'd0) begin failures++; $display("FAIL t5_clear_tuser got=%h exp=0", first_tuser); end
  endtask

  task automatic test_reset_mid_pkt();
    pattern = 16'hFFFF;
    do_clear();
    send_beat(mk(60), 32'hFFFFFFFF, 128'hF0, 1'b0);
    send_beat(mk(61), 32'hFFFFFFFF, 128'hF0, 1'b0);
    rst = 1'b1;
    tick();
    checks++; if (bus.tready !== 1'b0) begin failures++; $display("FAIL t6_rst_tready got=%b exp=0", bus.tready); end
    checks++; if ({beat_count, byte_count} !== 80'd0) begin
      failures++; $display("FAIL t6_rst_counts got=%0d/%0d exp=0/0", beat_count, byte_count);
    end
    tick();
    rst = 1'b0;
    send_beat(mk(62), 32'hFFFFFFFF, 128'hF6, 1'b0);
    send_beat(mk(63), 32'hFFFFFFFF, 128'hF7, 1'b0);
    send_beat(mk(64), 32'h00000003, 128'hF8, 1'b1);
    checks++; if (pkt_bytes !== 16'd66) begin failures++; $display("FAIL t6_pkt_bytes got=%0d exp=66", pkt_bytes); end
    checks++; if (pkt_count !== 32'd1) begin failures++; $display("FAIL t6_pkt_count got=%0d exp=1", pkt_count); end
    checks++; if (beat_count !== 32'd3) begin failures++; $display("FAIL t6_beat_count got=%0d exp=3", beat_count); end
    checks++; if (first_tuser !== 128'hF6) begin failures++; $display("FAIL t6_first_tuser got=%h exp=f6", first_tuser); end
    checks++; if ({err_keep, err_hold, err_len, err_overflow} !== 4'b0) begin
      failures++; $display("FAIL t6_errors got=%b exp=0000", {err_keep, err_hold, err_len, err_overflow});
    end
  endtask

  initial begin
    test_reset();
    test_basic_packet();
    test_backpressure();
    test_keep();
    test_overflow();
    test_len_and_clear();
    test_reset_mid_pkt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
